// File: rtl/valid_line_decoder.sv
// Cache line-select decoder with one valid bit per line, a running count of
// valid lines, and a flush engine that invalidates one line per cycle.
//
// state | meaning
// IDLE  | normal decode/lookup/set/clear; flush_req starts a flush
// FLUSH | clears valid[ptr] each cycle; accesses are blocked
module valid_line_decoder #(
  parameter int INDEX_W = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [INDEX_W-1:0]      index,
  input  logic                    en,
  input  logic                    set_valid,
  input  logic                    clr_valid,
  input  logic                    flush_req,
  output logic [(2**INDEX_W)-1:0] sel,
  output logic                    valid_out,
  output logic                    busy,
  output logic                    flush_done,
  output logic [INDEX_W:0]        valid_count
);

  localparam int LINES = 2**INDEX_W;
  localparam int CNT_W = INDEX_W + 1;

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [LINES-1:0]   valid_q;
  logic [INDEX_W-1:0] ptr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               done_q;
  logic               access, ptr_last, line_hit, flush_hit, inc, dec;

  assign access    = en & (state_q == IDLE);
  assign ptr_last  = (ptr_q == INDEX_W'(LINES - 1));
  assign line_hit  = valid_q[index];
  assign flush_hit = valid_q[ptr_q];

  // inc and dec are mutually exclusive: access needs IDLE, flush clearing needs FLUSH
  assign inc = access & set_valid & ~clr_valid & ~line_hit;
  assign dec = (access & clr_valid & line_hit) | ((state_q == FLUSH) & flush_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (flush_req) state_d = FLUSH;
      FLUSH:   if (ptr_last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == FLUSH);
    sel       = '0;
    if (access) sel[index] = 1'b1;
    valid_out = access & line_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state_q == FLUSH) & ptr_last;
      if (state_q == FLUSH) begin
        valid_q[ptr_q] <= 1'b0;
        ptr_q          <= ptr_last ? '0 : ptr_q + INDEX_W'(1);
      end else begin
        ptr_q <= '0;
        if (access & clr_valid)      valid_q[index] <= 1'b0;
        else if (access & set_valid) valid_q[index] <= 1'b1;
      end
      if (inc)      cnt_q <= cnt_q + CNT_W'(1);
      else if (dec) cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign valid_count = cnt_q;
  assign flush_done  = done_q;

endmodule

// File: tb/tb_valid_line_decoder.sv
// Bench for valid_line_decoder: 128-line instance for decode/set/clear and
// mid-flush reset, 4-line instance for fill/flush, 2-line for back-to-back.
module tb_valid_line_decoder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [6:0]   idx7;
  logic         en7, set7, clr7, fr7, vo7, busy7, done7;
  logic [127:0] sel7;
  logic [7:0]   cnt7;

  logic [1:0]   idx2;
  logic         en2, set2, clr2, fr2, vo2, busy2, done2;
  logic [3:0]   sel2;
  logic [2:0]   cnt2;

  logic         idx1;
  logic         en1, set1, clr1, fr1, vo1, busy1, done1;
  logic [1:0]   sel1;
  logic [1:0]   cnt1;

  valid_line_decoder #(.INDEX_W(7)) u7 (
    .clk(clk), .rst(rst), .index(idx7), .en(en7), .set_valid(set7),
    .clr_valid(clr7), .flush_req(fr7), .sel(sel7), .valid_out(vo7),
    .busy(busy7), .flush_done(done7), .valid_count(cnt7));

  valid_line_decoder #(.INDEX_W(2)) u2 (
    .clk(clk), .rst(rst), .index(idx2), .en(en2), .set_valid(set2),
    .clr_valid(clr2), .flush_req(fr2), .sel(sel2), .valid_out(vo2),
    .busy(busy2), .flush_done(done2), .valid_count(cnt2));

  valid_line_decoder #(.INDEX_W(1)) u1 (
    .clk(clk), .rst(rst), .index(idx1), .en(en1), .set_valid(set1),
    .clr_valid(clr1), .flush_req(fr1), .sel(sel1), .valid_out(vo1),
    .busy(busy1), .flush_done(done1), .valid_count(cnt1));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_sel(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] onehot(input int i);
    logic [127:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  typedef struct {
    int en; int idx; int set; int clr; int exp_sel_en; int exp_vo; int exp_cnt;
  } vec_t;

  // exp_vo is valid_out before the edge, exp_cnt is valid_count after it
  vec_t vt[15] = '{
    '{1,   0, 0, 0, 1, 0, 0},
    '{1, 127, 0, 0, 1, 0, 0},
    '{1,  37, 0, 0, 1, 0, 0},
    '{0,  37, 0, 0, 0, 0, 0},
    '{1,   5, 1, 0, 1, 0, 1},
    '{1,   5, 0, 0, 1, 1, 1},
    '{1,   5, 1, 0, 1, 1, 1},
    '{1,   9, 0, 1, 1, 0, 1},
    '{1,   5, 1, 1, 1, 1, 0},
    '{1,   5, 0, 0, 1, 0, 0},
    '{0,   5, 1, 0, 0, 0, 0},
    '{1,   5, 0, 0, 1, 0, 0},
    '{1, 100, 1, 0, 1, 0, 1},
    '{1, 100, 0, 0, 1, 1, 1},
    '{0, 100, 0, 0, 0, 0, 1}
  };

  int sb_cnt[$];

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones, busy_seen, exp_b, exp_d;
    int eb[6] = '{1, 1, 1, 1, 0, 0};
    int ec[6] = '{4, 3, 2, 1, 0, 0};
    int ed[6] = '{0, 0, 0, 0, 1, 0};

    idx7 = '0; en7 = 0; set7 = 0; clr7 = 0; fr7 = 0;
    idx2 = '0; en2 = 0; set2 = 0; clr2 = 0; fr2 = 0;
    idx1 = '0; en1 = 0; set1 = 0; clr1 = 0; fr1 = 0;

    #1 rst = 1'b1;
    #1;
    en7 = 1'b1;
    #1;
    chk("rst_busy7", 32'(busy7), 0);
    chk("rst_done7", 32'(done7), 0);
    chk("rst_cnt7",  32'(cnt7),  0);
    chk("rst_vo7",   32'(vo7),   0);
    chk_sel("rst_sel7", sel7, onehot(0));
    chk("rst_busy2", 32'(busy2), 0);
    chk("rst_done2", 32'(done2), 0);
    chk("rst_cnt2",  32'(cnt2),  0);
    chk("rst_vo2",   32'(vo2),   0);
    chk_sel("rst_sel2", 128'(sel2), '0);
    chk("rst_busy1", 32'(busy1), 0);
    chk("rst_done1", 32'(done1), 0);
    chk("rst_cnt1",  32'(cnt1),  0);
    chk("rst_vo1",   32'(vo1),   0);
    chk_sel("rst_sel1", 128'(sel1), '0);
    en7 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // decode / lookup / set / clear on the 128-line instance
    foreach (vt[i]) begin
      @(negedge clk);
      en7  = 1'(vt[i].en);
      idx7 = 7'(vt[i].idx);
      set7 = 1'(vt[i].set);
      clr7 = 1'(vt[i].clr);
      #1;
      chk_sel($sformatf("sel7_v%0d", i), sel7, (vt[i].exp_sel_en != 0) ? onehot(vt[i].idx) : '0);
      chk($sformatf("vo7_v%0d", i), 32'(vo7), vt[i].exp_vo);
      sb_cnt.push_back(vt[i].exp_cnt);
      @(posedge clk);
      #1;
      chk($sformatf("cnt7_v%0d", i), 32'(cnt7), sb_cnt.pop_front());
    end

    @(negedge clk);
    en7 = 1'b0; set7 = 1'b0; clr7 = 1'b0;
    for (int i = 0; i < 128; i++) begin
      idx7 = 7'(i);
      #0.1;
      chk_sel($sformatf("sel7_en0_%0d", i), sel7, '0);
    end

    // fill the 4-line instance; last set shares the cycle with flush_req
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      en2 = 1'b1; idx2 = 2'(i); set2 = 1'b1; fr2 = (i == 3);
      sb_cnt.push_back(i + 1);
      @(posedge clk);
      #1;
      chk($sformatf("fill_cnt2_%0d", i), 32'(cnt2), sb_cnt.pop_front());
    end

    // flush: accesses and flush_req during busy must be ignored
    dones = 0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (eb[j] != 0) begin
        en2 = 1'b1; idx2 = 2'd0; set2 = 1'b1; fr2 = 1'b1;
      end else begin
        en2 = 1'b0; set2 = 1'b0; fr2 = 1'b0;
      end
      #1;
      chk($sformatf("fl_busy2_%0d", j), 32'(busy2), eb[j]);
      chk($sformatf("fl_cnt2_%0d", j),  32'(cnt2),  ec[j]);
      chk($sformatf("fl_done2_%0d", j), 32'(done2), ed[j]);
      if (eb[j] != 0) begin
        chk_sel($sformatf("fl_sel2_%0d", j), 128'(sel2), '0);
        chk($sformatf("fl_vo2_%0d", j), 32'(vo2), 0);
      end
      if (done2) dones++;
    end
    chk("fl_done_pulses", 32'(dones), 1);
    @(negedge clk);
    en2 = 1'b1; idx2 = 2'd0;
    #1;
    chk("post_fl_vo2", 32'(vo2), 0);
    chk("post_fl_cnt2", 32'(cnt2), 0);
    chk("post_fl_busy2", 32'(busy2), 0);
    en2 = 1'b0;

    // back-to-back flushes on the 2-line instance
    @(negedge clk) fr1 = 1'b1;
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      #1;
      exp_b = ((j % 3) != 2) ? 1 : 0;
      exp_d = ((j % 3) == 2) ? 1 : 0;
      chk($sformatf("b2b_busy1_%0d", j), 32'(busy1), exp_b);
      chk($sformatf("b2b_done1_%0d", j), 32'(done1), exp_d);
    end
    fr1 = 1'b0;
    busy_seen = 0;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (busy1) busy_seen++;
    end
    chk("b2b_stop", 32'(busy_seen), 0);

    // reset in flush cycle 40 on the 128-line instance
    @(negedge clk);
    chk("pre_flush_cnt7", 32'(cnt7), 1);
    fr7 = 1'b1; en7 = 1'b0;
    @(negedge clk) fr7 = 1'b0;
    repeat (39) @(negedge clk);
    #1;
    chk("mid_busy7", 32'(busy7), 1);
    chk("mid_cnt7",  32'(cnt7),  1);
    rst = 1'b1;
    #1;
    chk("abort_busy7", 32'(busy7), 0);
    chk("abort_cnt7",  32'(cnt7),  0);
    @(negedge clk) rst = 1'b0;
    dones = 0; busy_seen = 0;
    repeat (140) begin
      @(negedge clk);
      #1;
      if (done7) dones++;
      if (busy7) busy_seen++;
    end
    chk("abort_no_done7", 32'(dones), 0);
    chk("abort_no_busy7", 32'(busy_seen), 0);
    en7 = 1'b1; idx7 = 7'd100;
    #1;
    chk("abort_vo7", 32'(vo7), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
